// File: rtl/cmul_seq_ctrl_pkg.sv
// Shared constants and state encoding for the complex twiddle-product sequencer.
// Q formats: data q9.7, twiddle q2.14, result q11.5.
package cmul_seq_ctrl_pkg;

  localparam int FRAC_A = 7;
  localparam int FRAC_B = 14;
  localparam int FRAC_R = 5;

  localparam int R_W   = 16;
  localparam int R_MAX = (2 ** (R_W - 1)) - 1;
  localparam int R_MIN = -(2 ** (R_W - 1));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cmul_seq_ctrl_sat_add.sv
// (W+1)-bit add/subtract reduced back to W bits.
// CMUL_SAT_EN defined: saturate to the W-bit signed range; undefined: two's-complement wrap.
module cmul_sat_add
  import cmul_seq_ctrl_pkg::*;
#(
  parameter int W = R_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y
);

  logic signed [W:0] a_x;
  logic signed [W:0] b_x;
  logic signed [W:0] sum;
  logic              sum_msb_unused;

  always_comb begin
    a_x = {a[W-1], a};
    b_x = {b[W-1], b};
    sum = sub ? (a_x - b_x) : (a_x + b_x);
`ifdef CMUL_SAT_EN
    // The extra bit disagreeing with the W-bit sign bit means the result left the range.
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y = sum[W-1:0];
    end
`else
    y = sum[W-1:0];
`endif
  end

  assign sum_msb_unused = sum[W];

endmodule

// File: rtl/cmul_seq_ctrl.sv
// Computes (ar + j*ai)*(wr + j*wi) with one shared external real multiplier, four products serially.
// Optional saturation of the final sums with CMUL_SAT_EN (see cmul_sat_add).
module cmul_seq_ctrl
  import cmul_seq_ctrl_pkg::*;
#(
  parameter int WIDTHa = 16,
  parameter int WIDTHb = 16,
  parameter int WIDTHr = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [WIDTHa-1:0] ar,
  input  logic [WIDTHa-1:0] ai,
  input  logic [WIDTHb-1:0] wr,
  input  logic [WIDTHb-1:0] wi,
  output logic              m_vld_in,
  output logic [WIDTHa-1:0] m_a,
  output logic [WIDTHb-1:0] m_b,
  input  logic              m_vld_out,
  input  logic [WIDTHr-1:0] m_r,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [WIDTHr-1:0] yr,
  output logic [WIDTHr-1:0] yi
);

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d, k_nx;
  logic [WIDTHa-1:0] ar_q, ar_d, ai_q, ai_d;
  logic [WIDTHb-1:0] wr_q, wr_d, wi_q, wi_d;
  logic              m_vld_in_q, m_vld_in_d;
  logic [WIDTHa-1:0] m_a_q, m_a_d;
  logic [WIDTHb-1:0] m_b_q, m_b_d;
  logic [WIDTHr-1:0] p_q [4];
  logic [WIDTHr-1:0] p_d [4];
  logic              out_vld_q, out_vld_d;
  logic [WIDTHr-1:0] yr_q, yr_d, yi_q, yi_d;
  logic [WIDTHr-1:0] sum_r, sum_i;

  assign k_nx = k_q + 2'd1;

  cmul_sat_add #(.W(WIDTHr)) u_add_re (
    .a  (p_q[0]),
    .b  (p_q[1]),
    .sub(1'b1),
    .y  (sum_r)
  );

  cmul_sat_add #(.W(WIDTHr)) u_add_im (
    .a  (p_q[2]),
    .b  (p_q[3]),
    .sub(1'b0),
    .y  (sum_i)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ar_d       = ar_q;
    ai_d       = ai_q;
    wr_d       = wr_q;
    wi_d       = wi_q;
    m_vld_in_d = 1'b0;
    m_a_d      = m_a_q;
    m_b_d      = m_b_q;
    p_d        = p_q;
    out_vld_d  = out_vld_q;
    yr_d       = yr_q;
    yi_d       = yi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_vld) begin
          ar_d       = ar;
          ai_d       = ai;
          wr_d       = wr;
          wi_d       = wi;
          k_d        = 2'd0;
          m_a_d      = ar;
          m_b_d      = wr;
          m_vld_in_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_vld_out) begin
          p_d[k_q] = m_r;
          if (k_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            // Order ar*wr, ai*wi, ar*wi, ai*wr: a alternates with k[0], b follows k[1]^k[0].
            k_d        = k_nx;
            m_a_d      = k_nx[0] ? ai_q : ar_q;
            m_b_d      = (k_nx[0] ^ k_nx[1]) ? wi_q : wr_q;
            m_vld_in_d = 1'b1;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        if (!out_vld_q) begin
          out_vld_d = 1'b1;
          yr_d      = sum_r;
          yi_d      = sum_i;
        end else if (out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      ar_q       <= '0;
      ai_q       <= '0;
      wr_q       <= '0;
      wi_q       <= '0;
      m_vld_in_q <= 1'b0;
      m_a_q      <= '0;
      m_b_q      <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
      out_vld_q  <= 1'b0;
      yr_q       <= '0;
      yi_q       <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ar_q       <= ar_d;
      ai_q       <= ai_d;
      wr_q       <= wr_d;
      wi_q       <= wi_d;
      m_vld_in_q <= m_vld_in_d;
      m_a_q      <= m_a_d;
      m_b_q      <= m_b_d;
      p_q        <= p_d;
      out_vld_q  <= out_vld_d;
      yr_q       <= yr_d;
      yi_q       <= yi_d;
    end
  end

  assign in_rdy   = (state_q == ST_IDLE) && !rst;
  assign m_vld_in = m_vld_in_q;
  assign m_a      = m_a_q;
  assign m_b      = m_b_q;
  assign out_vld  = out_vld_q;
  assign yr       = yr_q;
  assign yi       = yi_q;

endmodule
